// File: rtl/risc_mem_wb_pkg.sv
// Shared encodings and state type for the RISC memory/write-back stage.
package risc_pkg;

  localparam logic [1:0] MD_F   = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_SLT = 2'b10;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JR   = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  typedef enum logic {
    IDLE,
    MEM
  } state_t;

endpackage

// File: rtl/risc_mem_wb_if.sv
// Data-memory req/ack bus; the stage is the master, the memory the slave.
interface risc_mem_wb_if #(
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/risc_mem_wb_mux.sv
// Write-back value select driven by the MD control field.
module risc_wb_mux
  import risc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    md,
  input  logic [DW-1:0] f,
  input  logic [DW-1:0] rdata,
  input  logic          n_xor_v,
  output logic [DW-1:0] data
);

  always_comb begin
    data = f;
    case (md)
      MD_MEM:  data = rdata;
      MD_SLT:  data = {{(DW-1){1'b0}}, n_xor_v};
      default: data = f;
    endcase
  end

endmodule

// File: rtl/risc_mem_wb.sv
// Memory/write-back stage: data-memory access with timeout, write-back select
// and branch resolution. Stalls EX while a memory access is outstanding.
module risc_mem_wb
  import risc_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 16,
  parameter logic [DW-1:0] ERR_DATA = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_rw,
  input  logic [4:0]    ex_da,
  input  logic [1:0]    ex_md,
  input  logic [1:0]    ex_bs,
  input  logic          ex_ps,
  input  logic          ex_mw,
  input  logic [DW-1:0] ex_f,
  input  logic          ex_z,
  input  logic          ex_n_xor_v,
  input  logic [DW-1:0] ex_mem_addr,
  input  logic [DW-1:0] ex_mem_wdata,
  input  logic [DW-1:0] ex_bra,
  input  logic [DW-1:0] ex_raa,
  risc_mem_wb_if.master dm,
  output logic          wb_we,
  output logic [4:0]    wb_da,
  output logic [DW-1:0] wb_data,
  output logic          br_take,
  output logic [DW-1:0] br_target,
  output logic          dm_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          req_q, we_q;
  logic [DW-1:0] addr_q, wdata_q;
  logic          pend_load, pend_rw;
  logic [4:0]    pend_da;
  logic [DW-1:0] mux_data;
  logic          accept, is_mem, mem_ack, mem_timeout;

  assign dm.req   = req_q;
  assign dm.we    = we_q;
  assign dm.addr  = addr_q;
  assign dm.wdata = wdata_q;

  assign accept      = ex_valid && (state == IDLE);
  assign is_mem      = ex_mw || (ex_md == MD_MEM);
  assign mem_ack     = (state == MEM) && dm.ack;
  assign mem_timeout = (state == MEM) && !dm.ack && (cnt == CW'(TIMEOUT - 1));

  risc_wb_mux #(.DW(DW)) u_wb_mux (
    .md      (ex_md),
    .f       (ex_f),
    .rdata   (dm.rdata),
    .n_xor_v (ex_n_xor_v),
    .data    (mux_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ex_ready   = 1'b0;
    case (state)
      IDLE: begin
        ex_ready = 1'b1;
        if (accept && is_mem) state_next = MEM;
      end
      MEM: begin
        if (mem_ack || mem_timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write-back and branch strobes are single-cycle; R0 never gets written.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pend_load <= 1'b0;
      pend_rw   <= 1'b0;
      pend_da   <= '0;
      wb_we     <= 1'b0;
      wb_da     <= '0;
      wb_data   <= '0;
      br_take   <= 1'b0;
      br_target <= '0;
      dm_err    <= 1'b0;
    end else begin
      wb_we   <= 1'b0;
      br_take <= 1'b0;
      if (accept) begin
        case (ex_bs)
          BS_COND: if (ex_z == ex_ps) begin
            br_take   <= 1'b1;
            br_target <= ex_bra;
          end
          BS_JR: begin
            br_take   <= 1'b1;
            br_target <= ex_raa;
          end
          BS_JMP: begin
            br_take   <= 1'b1;
            br_target <= ex_bra;
          end
          default: ;
        endcase
        if (is_mem) begin
          req_q     <= 1'b1;
          we_q      <= ex_mw;
          addr_q    <= ex_mem_addr;
          wdata_q   <= ex_mem_wdata;
          pend_load <= !ex_mw;
          pend_rw   <= ex_rw;
          pend_da   <= ex_da;
          cnt       <= '0;
        end else begin
          wb_we   <= ex_rw && (ex_da != 5'd0);
          wb_da   <= ex_da;
          wb_data <= mux_data;
        end
      end else if (mem_ack) begin
        req_q <= 1'b0;
        if (pend_load) begin
          wb_we   <= pend_rw && (pend_da != 5'd0);
          wb_da   <= pend_da;
          wb_data <= dm.rdata;
        end
      end else if (mem_timeout) begin
        req_q  <= 1'b0;
        dm_err <= 1'b1;
        if (pend_load) begin
          wb_we   <= pend_rw && (pend_da != 5'd0);
          wb_da   <= pend_da;
          wb_data <= ERR_DATA;
        end
      end else if (state == MEM) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_risc_mem_wb.sv
// Scoreboard bench for risc_mem_wb: directed bundles, a negedge monitor
// compares every write-back and branch strobe against queued expectations.
module tb_risc_mem_wb;
  import risc_pkg::*;

  localparam int          DW       = 32;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'h0000_0000;

  typedef struct packed {
    logic [4:0]  da;
    logic [31:0] data;
  } wb_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ex_ready, ex_rw, ex_ps, ex_mw, ex_z, ex_n_xor_v;
  logic [4:0]    ex_da;
  logic [1:0]    ex_md, ex_bs;
  logic [31:0]   ex_f, ex_mem_addr, ex_mem_wdata, ex_bra, ex_raa;
  logic          wb_we, br_take, dm_err;
  logic [4:0]    wb_da;
  logic [31:0]   wb_data, br_target;

  int checks = 0;
  int errors = 0;

  wb_exp_t     wb_q[$];
  logic [31:0] br_q[$];

  risc_mem_wb_if #(.DW(DW)) dm ();

  risc_mem_wb #(.DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_rw        (ex_rw),
    .ex_da        (ex_da),
    .ex_md        (ex_md),
    .ex_bs        (ex_bs),
    .ex_ps        (ex_ps),
    .ex_mw        (ex_mw),
    .ex_f         (ex_f),
    .ex_z         (ex_z),
    .ex_n_xor_v   (ex_n_xor_v),
    .ex_mem_addr  (ex_mem_addr),
    .ex_mem_wdata (ex_mem_wdata),
    .ex_bra       (ex_bra),
    .ex_raa       (ex_raa),
    .dm           (dm.master),
    .wb_we        (wb_we),
    .wb_da        (wb_da),
    .wb_data      (wb_data),
    .br_take      (br_take),
    .br_target    (br_target),
    .dm_err       (dm_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents one bundle for exactly one accepting edge, returns #1 after it.
  task automatic applyStimulus(input logic rw, input logic [4:0] da,
                               input logic [1:0] md, input logic [1:0] bs,
                               input logic ps, input logic mw,
                               input logic [31:0] f, input logic z,
                               input logic nxv, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] bra,
                               input logic [31:0] raa);
    ex_rw = rw; ex_da = da; ex_md = md; ex_bs = bs; ex_ps = ps; ex_mw = mw;
    ex_f = f; ex_z = z; ex_n_xor_v = nxv; ex_mem_addr = addr;
    ex_mem_wdata = wdata; ex_bra = bra; ex_raa = raa;
    ex_valid = 1'b1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_we) begin
        if (wb_q.size() == 0) begin
          checkOutput("unexpected_wb_we", {27'd0, wb_da}, 32'hFFFF_FFFF);
        end else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          checkOutput("wb_da", {27'd0, wb_da}, {27'd0, e.da});
          checkOutput("wb_data", wb_data, e.data);
        end
      end
      if (br_take) begin
        if (br_q.size() == 0) begin
          checkOutput("unexpected_br_take", br_target, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] t;
          t = br_q.pop_front();
          checkOutput("br_target", br_target, t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_rw = 0; ex_da = 0; ex_md = 0; ex_bs = 0;
    ex_ps = 0; ex_mw = 0; ex_f = 0; ex_z = 0; ex_n_xor_v = 0;
    ex_mem_addr = 0; ex_mem_wdata = 0; ex_bra = 0; ex_raa = 0;
    dm.ack = 1'b0; dm.rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    checkOutput("rst_dm_req", {31'd0, dm.req}, 32'd0);
    checkOutput("rst_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("rst_dm_err", {31'd0, dm_err}, 32'd0);
    checkOutput("rst_br_target", br_target, 32'd0);

    // ALU results through the MD mux
    wb_q.push_back('{da: 5'd5, data: 32'd7});
    applyStimulus(1, 5'd5, MD_F, BS_NONE, 0, 0, 32'd7, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("add_ex_ready", {31'd0, ex_ready}, 32'd1);
    wb_q.push_back('{da: 5'd6, data: 32'd1});
    applyStimulus(1, 5'd6, MD_SLT, BS_NONE, 0, 0, 32'h1234, 0, 1, 0, 0, 0, 0);
    wb_q.push_back('{da: 5'd7, data: 32'h0000_ABCD});
    applyStimulus(1, 5'd7, 2'b11, BS_NONE, 0, 0, 32'hABCD, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Load, ack on the third request cycle
    wb_q.push_back('{da: 5'd3, data: 32'hCAFE_F00D});
    applyStimulus(1, 5'd3, MD_MEM, BS_NONE, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ld_req", {31'd0, dm.req}, 32'd1);
      checkOutput("ld_we", {31'd0, dm.we}, 32'd0);
      checkOutput("ld_addr", dm.addr, 32'h40);
      checkOutput("ld_ex_ready", {31'd0, ex_ready}, 32'd0);
      if (i == 2) begin
        dm.ack = 1'b1;
        dm.rdata = 32'hCAFE_F00D;
      end
    end
    @(posedge clk);
    #1 dm.ack = 1'b0;
    @(negedge clk);
    checkOutput("ld_req_drop", {31'd0, dm.req}, 32'd0);
    checkOutput("ld_ready_back", {31'd0, ex_ready}, 32'd1);

    // Store acknowledged in its first request cycle; no write-back allowed
    applyStimulus(1, 5'd9, MD_F, BS_NONE, 0, 1, 0, 0, 0, 32'h10, 32'h55, 0, 0);
    @(negedge clk);
    checkOutput("st_req", {31'd0, dm.req}, 32'd1);
    checkOutput("st_we", {31'd0, dm.we}, 32'd1);
    checkOutput("st_addr", dm.addr, 32'h10);
    checkOutput("st_wdata", dm.wdata, 32'h55);
    dm.ack = 1'b1;
    @(posedge clk);
    #1 dm.ack = 1'b0;
    @(negedge clk);
    checkOutput("st_req_drop", {31'd0, dm.req}, 32'd0);
    checkOutput("st_ready_back", {31'd0, ex_ready}, 32'd1);

    // Branches
    br_q.push_back(32'h100);
    applyStimulus(0, 5'd1, MD_F, BS_COND, 1, 0, 0, 1, 0, 0, 0, 32'h100, 32'h999);
    applyStimulus(0, 5'd1, MD_F, BS_COND, 1, 0, 0, 0, 0, 0, 0, 32'h180, 32'h999);
    @(negedge clk);
    checkOutput("br_not_taken_hold", br_target, 32'h100);
    br_q.push_back(32'h200);
    applyStimulus(0, 5'd1, MD_F, BS_JR, 0, 0, 0, 0, 0, 0, 0, 32'h111, 32'h200);
    br_q.push_back(32'h300);
    applyStimulus(0, 5'd1, MD_F, BS_JMP, 0, 0, 0, 1, 0, 0, 0, 32'h300, 32'h222);
    br_q.push_back(32'h340);
    applyStimulus(0, 5'd1, MD_F, BS_COND, 0, 0, 0, 0, 0, 0, 0, 32'h340, 32'h0);
    @(negedge clk);

    // Load that never gets an ack
    wb_q.push_back('{da: 5'd4, data: ERR_DATA});
    applyStimulus(1, 5'd4, MD_MEM, BS_NONE, 0, 0, 32'h77, 0, 0, 32'h80, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      checkOutput("to_req_held", {31'd0, dm.req}, 32'd1);
      checkOutput("to_err_low", {31'd0, dm_err}, 32'd0);
    end
    @(negedge clk);
    checkOutput("to_req_drop", {31'd0, dm.req}, 32'd0);
    checkOutput("to_err_set", {31'd0, dm_err}, 32'd1);
    checkOutput("to_ready_back", {31'd0, ex_ready}, 32'd1);
    dm.ack = 1'b1;
    @(negedge clk);
    dm.ack = 1'b0;
    checkOutput("late_ack_req", {31'd0, dm.req}, 32'd0);

    // R0 write is suppressed; error stays sticky
    applyStimulus(1, 5'd0, MD_F, BS_NONE, 0, 0, 32'h5A, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("err_sticky", {31'd0, dm_err}, 32'd1);

    // Reset in the second wait cycle, then a stale ack
    applyStimulus(1, 5'd2, MD_MEM, BS_NONE, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    dm.ack = 1'b1;
    dm.rdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("rstmid_req", {31'd0, dm.req}, 32'd0);
    checkOutput("rstmid_ready", {31'd0, ex_ready}, 32'd1);
    checkOutput("rstmid_err_clr", {31'd0, dm_err}, 32'd0);
    @(posedge clk);
    #1 dm.ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstmid_req_after", {31'd0, dm.req}, 32'd0);

    checkOutput("wb_queue_drained", wb_q.size(), 32'd0);
    checkOutput("br_queue_drained", br_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
